// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// The fetch stage drives requests as master; the memory answers in order as slave.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order imem requests, prefetch queue, IF/ID register, Decode redirects.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_unit #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clock,
    input  logic                reset,
    fetch_unit_if.master        imem,
    input  logic                id_if_selpcsource,
    input  logic [1:0]          id_if_selpctype,
    input  logic [31:0]         id_if_rega,
    input  logic [31:0]         id_if_pcimd2ext,
    input  logic [31:0]         id_if_pcindex,
    input  logic                id_stall,
    output logic [31:0]         if_id_instruc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]         if_id_nextpc,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_bubbles
`else
    output logic [31:0]         if_id_nextpc
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] nextpc;
    } entry_t;

    logic [31:0] fpc_q, fpc_d;
    logic [31:0] rpc_q, rpc_d;
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    cnt_t        qcount_q, qcount_d;
    cnt_t        outstanding_q, outstanding_d;
    cnt_t        drop_q, drop_d;
    logic [31:0] instruc_q, instruc_d;
    logic [31:0] nextpc_q, nextpc_d;
    entry_t      queue_q [DEPTH];

    logic        redirect;
    logic        req_valid;
    logic        accept;
    logic        keep;
    logic        pop;
    logic [31:0] target_raw;
    logic [31:0] target;
    cnt_t        occupancy;

    assign redirect = id_if_selpcsource & ~id_stall;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        target_raw = id_if_pcimd2ext;
        case (id_if_selpctype)
            2'b01:   target_raw = id_if_rega;
            2'b10:   target_raw = id_if_pcindex;
            default: target_raw = id_if_pcimd2ext;
        endcase
    end

    assign target = target_raw & ~32'd3;

    // Queued plus in-flight words never exceed DEPTH, so a kept response always has a free slot.
    assign occupancy = qcount_q + outstanding_q;
    assign req_valid = ~reset & ~redirect & (occupancy < cnt_t'(DEPTH));
    assign accept    = req_valid & imem.imem_req_ready;
    assign keep      = imem.imem_resp_valid & ~redirect & (drop_q == '0);
    assign pop       = ~id_stall & ~redirect & (qcount_q != '0);

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fpc_q;
    assign if_id_instruc       = instruc_q;
    assign if_id_nextpc        = nextpc_q;

    always_comb begin
        fpc_d         = fpc_q;
        rpc_d         = rpc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        qcount_d      = qcount_q;
        drop_d        = drop_q;
        instruc_d     = instruc_q;
        nextpc_d      = nextpc_q;
        outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(imem.imem_resp_valid);

        if (redirect) begin
            fpc_d    = target;
            rpc_d    = target;
            head_d   = tail_q;
            qcount_d = '0;
            // Everything still in flight after this edge belongs to the old path.
            drop_d   = outstanding_d;
        end else begin
            if (accept) fpc_d = fpc_q + 32'd4;
            if (keep) begin
                rpc_d  = rpc_q + 32'd4;
                tail_d = tail_q + ptr_t'(1);
            end
            if (pop) head_d = head_q + ptr_t'(1);
            qcount_d = qcount_q + cnt_t'(keep) - cnt_t'(pop);
            if (imem.imem_resp_valid && (drop_q != '0)) drop_d = drop_q - cnt_t'(1);
        end

        if (!id_stall) begin
            if (pop) begin
                {instruc_d, nextpc_d} = queue_q[head_q];
            end else begin
                instruc_d = NOP_INSTR;
                nextpc_d  = '0;
            end
        end
    end

    // NOTE: queue storage carries no reset; qcount/head/tail alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (keep) queue_q[tail_q] <= {imem.imem_resp_data, rpc_q + 32'd4};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fpc_q         <= RESET_PC;
            rpc_q         <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            qcount_q      <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            instruc_q     <= NOP_INSTR;
            nextpc_q      <= '0;
        end else begin
            fpc_q         <= fpc_d;
            rpc_q         <= rpc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            qcount_q      <= qcount_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            instruc_q     <= instruc_d;
            nextpc_q      <= nextpc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubbles_q, perf_bubbles_d;

    // A bubble is any non-stalled edge that loads NOP_INSTR instead of a queued word.
    always_comb begin
        perf_fetched_d = perf_fetched_q + {31'd0, keep};
        perf_bubbles_d = perf_bubbles_q + {31'd0, ~id_stall & ~pop};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model, queue-based reference model
// compared every cycle, plus directed literal checks from the test plan.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] nextpc;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clock;
  logic        reset;
  logic        id_if_selpcsource;
  logic [1:0]  id_if_selpctype;
  logic [31:0] id_if_rega;
  logic [31:0] id_if_pcimd2ext;
  logic [31:0] id_if_pcindex;
  logic        id_stall;
  logic [31:0] if_id_instruc;
  logic [31:0] if_id_nextpc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  fetch_unit_if imem ();

  fetch_unit #(
    .DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .imem(imem),
    .id_if_selpcsource(id_if_selpcsource),
    .id_if_selpctype(id_if_selpctype),
    .id_if_rega(id_if_rega),
    .id_if_pcimd2ext(id_if_pcimd2ext),
    .id_if_pcindex(id_if_pcindex),
    .id_stall(id_stall),
    .if_id_instruc(if_id_instruc),
`ifdef FETCH_PERF_CNT_EN
    .if_id_nextpc(if_id_nextpc),
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles)
`else
    .if_id_nextpc(if_id_nextpc)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hA5C3, a[15:0]};
  endfunction

  // Reference model state
  logic [31:0] m_fpc, m_rpc, m_instr, m_nextpc;
  ent_t        m_q[$];
  int          m_out, m_drop;
  int          m_fetched, m_bubbles;

  // Memory / environment state
  pend_t       pend[$];
  int          lat = 1;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_watch = 0;
  logic [31:0] watch_addr = 32'hFFFF_FFFF;
  logic        s_valid = 1'b0;
  logic [31:0] s_addr = 32'h0;
  bit          edge_nostall = 1'b0;
  int          tb_bubbles = 0;
  int          tb_instrs = 0;

  task automatic model_reset();
    m_fpc = 32'h0; m_rpc = 32'h0; m_q.delete();
    m_out = 0; m_drop = 0;
    m_instr = NOP; m_nextpc = 32'h0;
    m_fetched = 0; m_bubbles = 0;
  endtask

  function automatic bit model_req_valid();
    bit redir;
    redir = id_if_selpcsource && !id_stall;
    return !reset && !redir && ((m_q.size() + m_out) < DEPTH);
  endfunction

  task automatic model_step();
    bit          redir, valid, acc, rv, keep;
    logic [31:0] tgt;
    ent_t        e;
    redir = id_if_selpcsource && !id_stall;
    case (id_if_selpctype)
      2'b01:   tgt = id_if_rega;
      2'b10:   tgt = id_if_pcindex;
      default: tgt = id_if_pcimd2ext;
    endcase
    tgt[1:0] = 2'b00;
    valid = !redir && ((m_q.size() + m_out) < DEPTH);
    acc   = valid && imem.imem_req_ready;
    rv    = imem.imem_resp_valid;
    keep  = rv && !redir && (m_drop == 0);
    m_out = m_out + int'(acc) - int'(rv);
    if (rv && m_drop > 0) m_drop--;
    if (!id_stall) begin
      if (!redir && m_q.size() > 0) begin
        e = m_q.pop_front();
        m_instr = e.instr;
        m_nextpc = e.nextpc;
      end else begin
        m_instr = NOP;
        m_nextpc = 32'h0;
        m_bubbles++;
      end
    end
    if (keep) begin
      m_q.push_back('{instr: imem.imem_resp_data, nextpc: m_rpc + 32'd4});
      m_rpc = m_rpc + 32'd4;
      m_fetched++;
    end
    if (acc) m_fpc = m_fpc + 32'd4;
    if (redir) begin
      m_fpc = tgt;
      m_rpc = tgt;
      m_q.delete();
      m_drop = m_out;
    end
  endtask

  // Model update and in-order memory, both on the rising edge.
  initial begin
    imem.imem_resp_valid = 1'b0;
    imem.imem_resp_data  = 32'hDEAD_BEEF;
    model_reset();
    forever begin
      @(posedge clock);
      if (reset) begin
        model_reset();
        pend.delete();
        n_acc = 0;
        tb_bubbles = 0;
        tb_instrs = 0;
        edge_nostall = 1'b0;
      end else begin
        model_step();
        edge_nostall = !id_stall;
        if (imem.imem_resp_valid) void'(pend.pop_front());
        if (s_valid && imem.imem_req_ready) begin
          pend.push_back('{addr: s_addr, due: cyc + lat});
          n_acc++;
          if (s_addr == watch_addr) n_watch++;
        end
      end
      cyc++;
      #1;
      if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
        imem.imem_resp_valid = 1'b1;
        imem.imem_resp_data  = mem_word(pend[0].addr);
      end else begin
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Per-cycle comparison against the model, then a late sample of the request for the memory.
  always @(negedge clock) begin
    if (!reset) begin
      bit ev;
      ev = model_req_valid();
      check("cmp_req_valid", {31'd0, imem.imem_req_valid}, {31'd0, ev});
      if (ev) check("cmp_req_addr", imem.imem_req_addr, m_fpc);
      check("cmp_instruc", if_id_instruc, m_instr);
      check("cmp_nextpc", if_id_nextpc, m_nextpc);
`ifdef FETCH_PERF_CNT_EN
      check("cmp_perf_fetched", perf_fetched, m_fetched);
      check("cmp_perf_bubbles", perf_bubbles, m_bubbles);
`endif
      if (edge_nostall) begin
        if (if_id_instruc == NOP) tb_bubbles++;
        else tb_instrs++;
      end
    end
    #4;
    s_valid = imem.imem_req_valid;
    s_addr  = imem.imem_req_addr;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Advance until Decode sees a real instruction, then check it against the literal expectation.
  task automatic wait_out(input string name, input logic [31:0] exp_i, input logic [31:0] exp_pc);
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (if_id_instruc != NOP) begin
        check({name, "_instr"}, if_id_instruc, exp_i);
        check({name, "_nextpc"}, if_id_nextpc, exp_pc);
        #1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout, no instruction reached Decode (expected 0x%08h)", name, exp_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_i, hold_pc;
    int          acc0;

    reset = 1'b1;
    id_if_selpcsource = 1'b0;
    id_if_selpctype = 2'b00;
    id_if_rega = 32'h0;
    id_if_pcimd2ext = 32'h0;
    id_if_pcindex = 32'h0;
    id_stall = 1'b0;
    imem.imem_req_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_instruc", if_id_instruc, NOP);
    check("rst_nextpc", if_id_nextpc, 32'h0);
    check("rst_req_valid", {31'd0, imem.imem_req_valid}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("first_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
    check("first_req_addr", imem.imem_req_addr, 32'h0);
    #1;
    step();
    step();
    step();
    @(negedge clock);
    check("third_edge_instr", if_id_instruc, mem_word(32'h0));
    check("third_edge_nextpc", if_id_nextpc, 32'h4);
    #1;
    wait_out("seq1", mem_word(32'h4), 32'h8);
    wait_out("seq2", mem_word(32'h8), 32'hC);
    wait_out("seq3", mem_word(32'hC), 32'h10);

    // Queue full: stall Decode with memory always ready
    id_stall = 1'b1;
    hold_i = if_id_instruc;
    hold_pc = if_id_nextpc;
    acc0 = n_acc;
    repeat (10) step();
    @(negedge clock);
    check("qfull_accepts_le_depth", {31'd0, (n_acc - acc0) <= DEPTH}, 32'd1);
    check("qfull_req_valid", {31'd0, imem.imem_req_valid}, 32'd0);
    check("qfull_hold_instr", if_id_instruc, hold_i);
    check("qfull_hold_nextpc", if_id_nextpc, hold_pc);
    #1 id_stall = 1'b0;
    wait_out("qfull_resume1", mem_word(hold_pc), hold_pc + 32'd4);
    wait_out("qfull_resume2", mem_word(hold_pc + 32'd4), hold_pc + 32'd8);

    // Branch redirect with two requests in flight (3-cycle memory)
    lat = 3;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_out == 2) break;
    end
    check("br_two_in_flight", m_out, 32'd2);
    id_if_selpcsource = 1'b1;
    id_if_selpctype = 2'b00;
    id_if_pcimd2ext = 32'h100;
    id_if_rega = 32'h444;
    id_if_pcindex = 32'h888;
    step();
    id_if_selpcsource = 1'b0;
    @(negedge clock);
    check("br_req_addr", imem.imem_req_addr, 32'h100);
    #1;
    wait_out("br_target", mem_word(32'h100), 32'h104);
    wait_out("br_next", mem_word(32'h104), 32'h108);

    // Register-jump redirect: low bits of the target are cleared
    lat = 1;
    repeat (3) step();
    id_if_selpcsource = 1'b1;
    id_if_selpctype = 2'b01;
    id_if_rega = 32'h203;
    step();
    id_if_selpcsource = 1'b0;
    @(negedge clock);
    check("rj_req_addr", imem.imem_req_addr, 32'h200);
    #1;
    wait_out("rj_target", mem_word(32'h200), 32'h204);

    // Index-jump redirect
    repeat (2) step();
    id_if_selpcsource = 1'b1;
    id_if_selpctype = 2'b10;
    id_if_pcindex = 32'h2A1;
    step();
    id_if_selpcsource = 1'b0;
    wait_out("ix_target", mem_word(32'h2A0), 32'h2A4);

    // Selpctype 11 behaves as 00
    repeat (2) step();
    id_if_selpcsource = 1'b1;
    id_if_selpctype = 2'b11;
    id_if_pcimd2ext = 32'h182;
    step();
    id_if_selpcsource = 1'b0;
    wait_out("sel11_target", mem_word(32'h180), 32'h184);

    // Stall versus redirect
    watch_addr = 32'h300;
    n_watch = 0;
    id_if_selpctype = 2'b00;
    id_if_pcimd2ext = 32'h300;
    id_if_selpcsource = 1'b1;
    id_stall = 1'b1;
    repeat (2) step();
    @(negedge clock);
    check("sv_no_req_during_stall", n_watch, 32'd0);
    check("sv_addr_not_target", {31'd0, imem.imem_req_addr == 32'h300}, 32'd0);
    #1 id_stall = 1'b0;
    step();
    id_if_selpcsource = 1'b0;
    wait_out("sv_target", mem_word(32'h300), 32'h304);
    repeat (6) step();
    check("sv_single_redirect", n_watch, 32'd1);

    // Performance: reset mid-stream, 3-cycle memory, exactly 8 instructions
    reset = 1'b1;
    lat = 3;
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (n_acc >= 8) imem.imem_req_ready = 1'b0;
    end
    @(negedge clock);
    check("perf_acc_count", n_acc, 32'd8);
    check("perf_instr_count", tb_instrs, 32'd8);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'd8);
    check("perf_bubbles", perf_bubbles, tb_bubbles);
`endif
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
